// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Bus semantics: mem_cmd acts as the valid qualifier for mem_addr/write_data and
// the block is always ready, so every MREAD/MWRITE is accepted on the edge that
// samples it; read results appear one cycle later on read_data with read_hit.
module mmio_uart_tx #(
  parameter int         CLKS_PER_BIT = 4,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [8:0] TX_ADDR      = 9'h140,
  parameter logic [8:0] STAT_ADDR    = 9'h141
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_hit,
  output logic        tx,
  output logic [1:0]  dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      last_q, last_d;
  logic [15:0]     read_data_q, read_data_d;
  logic            read_hit_q, read_hit_d;

  logic            pop;
  logic            push;
  logic            drop;
  logic            empty;
  logic            full;
  logic            busy;
  logic            bit_end;
  logic            wr_tx;
  logic            rd_stat;
  logic            rd_tx;
  logic [15:0]     status;
  logic            unused_hi;

  assign unused_hi = ^write_data[15:8];

  assign empty   = (count_q == 4'd0);
  assign full    = (count_q == 4'(FIFO_DEPTH));
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (bit_cnt_q == CNT_LAST);
  assign wr_tx   = (mem_cmd == MWRITE) && (mem_addr == TX_ADDR);
  assign rd_stat = (mem_cmd == MREAD) && (mem_addr == STAT_ADDR);
  assign rd_tx   = (mem_cmd == MREAD) && (mem_addr == TX_ADDR);
  assign status  = {8'h00, count_q, overflow_q, empty, full, busy};

  // Transmit FSM: bit timing, byte pops from the FIFO and the next tx level.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = fifo_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (!empty) begin
            // Back-to-back: next start bit follows the stop bit directly.
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // tx is registered, so it is derived from the state being entered.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO push/drop, sticky overflow, last-byte register and read mux.
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    push        = 1'b0;
    drop        = 1'b0;
    read_data_d = 16'h0000;
    read_hit_d  = 1'b0;
    if (wr_tx) begin
      last_d = write_data[7:0];
      // A pop on the same edge frees a slot, so a full FIFO still accepts.
      if (!full || pop) begin
        push             = 1'b1;
        fifo_d[wr_ptr_q] = write_data[7:0];
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d    = count_q + 4'(push) - 4'(pop);
    // A drop on the reading edge wins over the clear.
    overflow_d = (overflow_q && !rd_stat) || drop;
    if (rd_stat) begin
      read_data_d = status;
      read_hit_d  = 1'b1;
    end else if (rd_tx) begin
      read_data_d = {8'h00, last_q};
      read_hit_d  = 1'b1;
    end
  end

  // State registers with synchronous reset; FIFO storage needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      overflow_q  <= 1'b0;
      last_q      <= 8'h00;
      read_data_q <= 16'h0000;
      read_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_q      <= last_d;
      read_data_q <= read_data_d;
      read_hit_q  <= read_hit_d;
    end
    fifo_q <= fifo_d;
  end

  assign read_data = read_data_q;
  assign read_hit  = read_hit_q;
  assign tx        = tx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_hit;
  logic        tx;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int ft    = 0;
  logic [7:0] exp_q[$];

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [8:0] A_TX   = 9'h140;
  localparam logic [8:0] A_STAT = 9'h141;

  mmio_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .TX_ADDR     (9'h140),
    .STAT_ADDR   (9'h141)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .read_hit  (read_hit),
    .tx        (tx),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    step();
    mem_cmd    = MNONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
  endtask

  task automatic adv(input int target);
    while (ft < target) begin
      step();
      ft++;
    end
  endtask

  task automatic read_stat(input string tag, input logic [15:0] exp);
    bus(MREAD, A_STAT, 16'h0000);
    ft++;
    check_vec({tag, " data"}, read_data, exp);
    check_vec({tag, " hit"}, 16'(read_hit), 16'h0001);
  endtask

  // Scoreboard: decode one frame at bit centres (t = 0 is the first start-bit cycle).
  task automatic recv_frame(input int t_now, input string tag);
    logic [7:0] b;
    logic [7:0] e;
    b  = 8'h00;
    ft = t_now;
    if (ft <= 2) begin
      adv(2);
      check_vec({tag, " start"}, 16'(tx), 16'h0000);
    end
    for (int k = 0; k < 8; k++) begin
      adv(6 + 4 * k);
      b[k] = tx;
    end
    adv(38);
    check_vec({tag, " stop"}, 16'(tx), 16'h0001);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s data: got %h expected none", tag, b);
    end else begin
      e = exp_q.pop_front();
      check_vec({tag, " data"}, {8'h00, b}, {8'h00, e});
    end
  endtask

  task automatic expect_b2b(input string tag);
    adv(40);
    check_vec({tag, " b2b start"}, 16'(tx), 16'h0000);
  endtask

  task automatic watch_idle(input int n, input string tag);
    logic saw_low;
    saw_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check_vec(tag, 16'(saw_low), 16'h0000);
  endtask

  initial begin
    logic [9:0] seq;
    logic       hit_seen;
    reset      = 1'b1;
    mem_cmd    = MNONE;
    mem_addr   = 9'h000;
    write_data = 16'h0000;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and idle line
    check_vec("rst tx", 16'(tx), 16'h0001);
    check_vec("rst read_data", read_data, 16'h0000);
    check_vec("rst read_hit", 16'(read_hit), 16'h0000);
    check_vec("rst state", 16'(dbg_state), 16'h0000);
    hit_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (read_hit !== 1'b0) hit_seen = 1'b1;
    end
    check_vec("idle read_hit", 16'(hit_seen), 16'h0000);
    watch_idle(1, "idle tx");
    read_stat("stat empty", 16'h0004);
    step();
    check_vec("hit one cycle", 16'(read_hit), 16'h0000);

    // Single frame 0x55: exact per-cycle waveform
    bus(MWRITE, A_TX, 16'hAB55);
    check_vec("pre start tx", 16'(tx), 16'h0001);
    seq = 10'b1_01010101_0;
    for (int i = 0; i < 40; i++) begin
      step();
      check_vec($sformatf("wave t%0d", i), 16'(tx), 16'(seq[i / 4]));
    end
    step();
    check_vec("after frame tx", 16'(tx), 16'h0001);
    read_stat("stat after frame", 16'h0004);

    // Three back-to-back frames
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    bus(MWRITE, A_TX, 16'h0001);
    bus(MWRITE, A_TX, 16'h0002);
    bus(MWRITE, A_TX, 16'h0003);
    ft = 1;
    read_stat("stat mid frame", 16'h0021);
    recv_frame(ft, "f1");
    expect_b2b("f1");
    recv_frame(0, "f2");
    expect_b2b("f2");
    recv_frame(0, "f3");
    adv(40);
    check_vec("f3 end idle", 16'(tx), 16'h0001);
    read_stat("stat after f3", 16'h0004);

    // Overflow: one in flight, four queued, fifth dropped
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) bus(MWRITE, A_TX, 16'h0000 | 16'(8'hA0 + 8'(i)));
    ft = 4;
    read_stat("stat overflow", 16'h004B);
    read_stat("stat ovf cleared", 16'h0043);
    recv_frame(ft, "o0");
    // Push while full on the same edge as the stop-bit pop is accepted.
    adv(39);
    exp_q.push_back(8'hA6);
    bus(MWRITE, A_TX, 16'h00A6);
    ft = 0;
    check_vec("o0 b2b start", 16'(tx), 16'h0000);
    read_stat("stat push+pop full", 16'h0043);
    recv_frame(ft, "o1");
    expect_b2b("o1");
    recv_frame(0, "o2");
    expect_b2b("o2");
    recv_frame(0, "o3");
    expect_b2b("o3");
    recv_frame(0, "o4");
    expect_b2b("o4");
    recv_frame(0, "o6");
    adv(40);
    watch_idle(60, "dropped byte not sent");
    check_vec("scoreboard drained", 16'(exp_q.size()), 16'h0000);
    read_stat("stat after ovf", 16'h0004);

    // Reset during bit 3 with two bytes queued
    bus(MWRITE, A_TX, 16'h00B0);
    bus(MWRITE, A_TX, 16'h00B1);
    bus(MWRITE, A_TX, 16'h00B2);
    ft = 1;
    adv(17);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("mid rst tx", 16'(tx), 16'h0001);
    check_vec("mid rst state", 16'(dbg_state), 16'h0000);
    check_vec("mid rst read_hit", 16'(read_hit), 16'h0000);
    watch_idle(100, "no frames after rst");
    read_stat("stat after rst", 16'h0004);

    // Address/command decode
    bus(MNONE, A_STAT, 16'h0000);
    check_vec("mnone stat data", read_data, 16'h0000);
    check_vec("mnone stat hit", 16'(read_hit), 16'h0000);
    bus(MWRITE, 9'h100, 16'h00FF);
    check_vec("wr 100 data", read_data, 16'h0000);
    check_vec("wr 100 hit", 16'(read_hit), 16'h0000);
    bus(MREAD, 9'h0FF, 16'h0000);
    check_vec("rd 0ff data", read_data, 16'h0000);
    check_vec("rd 0ff hit", 16'(read_hit), 16'h0000);
    bus(2'b11, A_STAT, 16'h0000);
    check_vec("cmd11 hit", 16'(read_hit), 16'h0000);
    bus(MWRITE, A_TX, 16'h005A);
    bus(MREAD, A_TX, 16'h0000);
    check_vec("last byte 5a", read_data, 16'h005A);
    check_vec("last byte hit", 16'(read_hit), 16'h0001);
    bus(MWRITE, A_TX, 16'h12A5);
    bus(MREAD, A_TX, 16'h0000);
    check_vec("last byte hi ignored", read_data, 16'h00A5);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
